mat_operand_loader: RTL

MAT_OPERAND_LOADER -- requirements
Module: mat_operand_loader

---
 rtl/mat_operand_loader.sv | 85 ++++++++
 1 files changed

// File: rtl/mat_operand_loader.sv
// mat_operand_loader: serial 2x2 operand loader that holds A/B for a multiplier and captures its result
module mat_operand_loader #(
    parameter int WIDTH       = 8,
    parameter int HOLD_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [4*WIDTH-1:0] A,
    output logic [4*WIDTH-1:0] B,
    output logic               op_valid,
    input  logic [63:0]        Res,
    output logic [63:0]        res_data,
    output logic               res_valid,
    input  logic               res_ready
);
    typedef enum logic [1:0] {LOAD, HOLD, OUT} state_t;
    state_t             r_state;
    state_t             w_next;
    logic [2:0]         r_beat;
    logic [3:0]         r_hold;
    logic [4*WIDTH-1:0] r_a;
    logic [4*WIDTH-1:0] r_b;
    logic [63:0]        r_res;
    logic [1:0]         w_slot;
    logic               w_xfer;
    logic               w_last_beat;
    logic               w_hold_done;
    logic               w_release;
    assign w_xfer      = in_valid && r_state == LOAD;
    assign w_last_beat = w_xfer && r_beat == 3'd7;
    assign w_hold_done = r_state == HOLD && r_hold == 4'd0;
    assign w_release   = r_state == OUT && res_ready;
    // element [0][0] sits in the top slot, so slot index runs opposite to the beat order
    assign w_slot      = ~r_beat[1:0];
    assign in_ready    = r_state == LOAD;
    assign op_valid    = r_state == HOLD;
    assign res_valid   = r_state == OUT;
    assign A           = r_a;
    assign B           = r_b;
    assign res_data    = r_res;
    // state register
    always_ff @(posedge clk) begin
        r_state <= reset ? LOAD : w_next;
    end
    // next state: finish load, finish hold, or consumer handshake
    always_comb begin
        w_next = w_last_beat ? HOLD : w_hold_done ? OUT : w_release ? LOAD : r_state;
    end
    // beat and hold counters; the 3-bit beat counter wraps to 0 after beat 7
    always_ff @(posedge clk) begin
        if (reset) begin
            r_beat <= '0;
            r_hold <= '0;
        end else begin
            if (w_xfer)
                r_beat <= r_beat + 3'd1;
            if (w_last_beat)
                r_hold <= 4'(HOLD_CYCLES - 1);
            else if (r_state == HOLD && r_hold != 4'd0)
                r_hold <= r_hold - 4'd1;
        end
    end
    // operand registers: each transfer writes exactly one element
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a <= '0;
            r_b <= '0;
        end else if (w_xfer) begin
            if (r_beat[2])
                r_b[w_slot*WIDTH +: WIDTH] <= in_data;
            else
                r_a[w_slot*WIDTH +: WIDTH] <= in_data;
        end
    end
    // result capture on the edge ending the last hold cycle
    always_ff @(posedge clk) begin
        if (reset)
            r_res <= '0;
        else if (w_hold_done)
            r_res <= Res;
    end
endmodule
